// File: rtl/alu_seq_pkg.sv
// Sequencer state encoding and default multiply iteration count.
package alu_seq_pkg;
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    RESP
  } seqState_t;

  localparam int unsigned MUL_ITERS_DEFAULT = 32;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU word and ALU opcode types used by the ALU and everything that drives it.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } aluop_t;
endpackage

// File: rtl/alu_if.sv
// ALU operand/result bundle; tb modport drives operands, alu modport produces results.
interface alu_if;
  import cpu_types_pkg::*;

  word_t       portA;
  word_t       portB;
  logic [3:0]  ALUOP;
  word_t       portOut;
  logic        neg_flag;
  logic        zero_flag;
  logic        of_flag;

  modport tb  (output portA, portB, ALUOP, input  portOut, neg_flag, zero_flag, of_flag);
  modport alu (input  portA, portB, ALUOP, output portOut, neg_flag, zero_flag, of_flag);
endinterface

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes yield zero. Overflow is signed and only set by ADD/SUB.
module alu
  import cpu_types_pkg::*;
(
  alu_if.alu aluif
);
  word_t res;
  logic  of;

  always_comb begin
    res = '0;
    of  = 1'b0;
    case (aluif.ALUOP)
      ALU_SLL:  res = aluif.portA << aluif.portB[4:0];
      ALU_SRL:  res = aluif.portA >> aluif.portB[4:0];
      ALU_ADD: begin
        res = aluif.portA + aluif.portB;
        of  = (aluif.portA[31] == aluif.portB[31]) && (res[31] != aluif.portA[31]);
      end
      ALU_SUB: begin
        res = aluif.portA - aluif.portB;
        of  = (aluif.portA[31] != aluif.portB[31]) && (res[31] != aluif.portA[31]);
      end
      ALU_AND:  res = aluif.portA & aluif.portB;
      ALU_OR:   res = aluif.portA | aluif.portB;
      ALU_XOR:  res = aluif.portA ^ aluif.portB;
      ALU_NOR:  res = ~(aluif.portA | aluif.portB);
      ALU_SLT:  res = {31'b0, $signed(aluif.portA) < $signed(aluif.portB)};
      ALU_SLTU: res = {31'b0, aluif.portA < aluif.portB};
      default:  res = '0;
    endcase
  end

  assign aluif.portOut   = res;
  assign aluif.neg_flag  = res[31];
  assign aluif.zero_flag = (res == '0);
  assign aluif.of_flag   = of;
endmodule

// File: rtl/alu_seq_mul_dp.sv
// Shift-add multiply datapath: acc/mcand/mplier/count registers and loop exit condition.
// ALU_SEQ_MUL_EARLY_EN: also exit once the remaining multiplier bits are all zero.
module alu_seq_mul_dp
  import cpu_types_pkg::*;
#(
  parameter int unsigned MUL_ITERS = 32
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  step,
  input  word_t mcandIn,
  input  word_t mplierIn,
  input  word_t aluSum,
  output word_t acc,
  output word_t mcand,
  output word_t accNext,
  output logic  done
);
  localparam int unsigned CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

  logic [CW-1:0] count;
  word_t         mplier;
  word_t         mplierNext;
  logic          lastIter;

  // aluSum is acc + mcand this cycle; keep it only when the current multiplier bit is set
  assign accNext    = mplier[0] ? aluSum : acc;
  assign mplierNext = mplier >> 1;
  assign lastIter   = (count == CW'(MUL_ITERS - 1));

`ifdef ALU_SEQ_MUL_EARLY_EN
  assign done = lastIter || (mplierNext == '0);
`else
  assign done = lastIter;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= mcandIn;
      mplier <= mplierIn;
      count  <= '0;
    end else if (step) begin
      acc    <= accNext;
      mcand  <= mcand << 1;
      mplier <= mplierNext;
      count  <= count + CW'(1);
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response front end that drives an ALU via alu_if; multiply is an iterative ADD loop.
// ALU_SEQ_MUL_EARLY_EN shortens multiply latency when the multiplier runs out of set bits.
module alu_op_sequencer
  import cpu_types_pkg::*;
  import alu_seq_pkg::*;
#(
  parameter int unsigned MUL_ITERS = MUL_ITERS_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mul,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_neg,
  output logic        rsp_zero,
  output logic        rsp_of,
  alu_if.tb           aluif
);
  seqState_t  state;
  word_t      opA;
  word_t      opB;
  logic [3:0] op;
  word_t      acc;
  word_t      mcand;
  word_t      accNext;
  logic       mulDone;
  logic       accept;

  assign accept = req_valid && req_ready && (state == IDLE);

  alu_seq_mul_dp #(.MUL_ITERS(MUL_ITERS)) mulDp (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept && req_mul),
    .step     (state == MUL),
    .mcandIn  (req_a),
    .mplierIn (req_b),
    .aluSum   (aluif.portOut),
    .acc      (acc),
    .mcand    (mcand),
    .accNext  (accNext),
    .done     (mulDone)
  );

  always_comb begin
    aluif.portA = '0;
    aluif.portB = '0;
    aluif.ALUOP = 4'h0;
    case (state)
      EXEC: begin
        aluif.portA = opA;
        aluif.portB = opB;
        aluif.ALUOP = op;
      end
      MUL: begin
        aluif.portA = acc;
        aluif.portB = mcand;
        aluif.ALUOP = ALU_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_neg   <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_of    <= 1'b0;
      opA       <= '0;
      opB       <= '0;
      op        <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opA       <= req_a;
            opB       <= req_b;
            op        <= req_op;
            req_ready <= 1'b0;
            state     <= req_mul ? MUL : EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= aluif.portOut;
          rsp_neg   <= aluif.neg_flag;
          rsp_zero  <= aluif.zero_flag;
          rsp_of    <= aluif.of_flag;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        MUL: begin
          // Flags come from the final accumulator, not the ALU's last ADD
          if (mulDone) begin
            rsp_data  <= accNext;
            rsp_neg   <= accNext[31];
            rsp_zero  <= (accNext == '0);
            rsp_of    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
